// File: rtl/qqspi_pkg.sv
// qqspi_pkg: command codes, FSM state encoding and read-data helper shared by the qqspi master and target
package qqspi_pkg;
  localparam logic [7:0] CMD_WRITE_SPI = 8'h02;
  localparam logic [7:0] CMD_READ_SPI = 8'h03;
  localparam logic [7:0] CMD_WRITE_QUAD = 8'h38;
  localparam logic [7:0] CMD_READ_QUAD = 8'heb;
  localparam int WAIT_CLKS_DEF = 6;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD = 3'd1,
    S_ADDR = 3'd2,
    S_WAIT = 3'd3,
    S_RDATA = 3'd4,
    S_WDATA = 3'd5,
    S_DROP = 3'd6
  } state_e;
  // Pad pattern for the top unit of a read word: a full nibble in quad mode, bit 31 on miso otherwise.
  function automatic logic [3:0] out_unit(input logic [3:0] top, input bit quad);
    return quad ? top : {2'b00, top[3], 1'b0};
  endfunction
endpackage

// File: rtl/qqspi_psram_target_if.sv
// qqspi_psram_target_if: serial link between qqspi master and PSRAM target
//   ss      active-low slave select (master -> target)
//   sclk    serial clock, idle low (master -> target)
//   sio_di  {sio3,sio2,miso,mosi} as seen at the target pad inputs
//   sio_do  target pad outputs
//   sio_oe  target pad output enables
interface qqspi_psram_target_if;
  logic ss;
  logic sclk;
  logic [3:0] sio_di;
  logic [3:0] sio_do;
  logic [3:0] sio_oe;
  modport master (output ss, sclk, sio_di, input sio_do, sio_oe);
  modport slave (input ss, sclk, sio_di, output sio_do, sio_oe);
endinterface

// File: rtl/qqspi_sync_edge.sv
// qqspi_sync_edge: 2-FF synchronizer with single-clk rise/fall pulses on the synced level
//   clk, reset  system clock, async active-high reset
//   d_i         asynchronous input
//   rise_o      1-clk pulse on synced 0->1
//   fall_o      1-clk pulse on synced 1->0
module qqspi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);
  logic [2:0] s_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) s_q <= {3{RST_VAL}};
    else s_q <= {s_q[1:0], d_i};
  end
  assign rise_o = s_q[1] & ~s_q[2];
  assign fall_o = ~s_q[1] & s_q[2];
endmodule

// File: rtl/qqspi_psram_target.sv
// qqspi_psram_target: QSPI/SPI PSRAM responder serving single-word transactions from an internal word RAM
//   clk, reset   system clock (>= 8x sclk), async active-high reset
//   bus          qqspi link, target side
//   host_addr    side-port word address; host_rdata follows 1 clk later
//   host_wdata   side-port write data, written on host_we
//   state        current FSM state
//   xfer_done    1-clk pulse when a read or write completes cleanly
module qqspi_psram_target
  import qqspi_pkg::*;
#(
  parameter int QUAD_MODE = 1,
  parameter int ADDR_BITS = 10,
  parameter int WAIT_CLKS = WAIT_CLKS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  qqspi_psram_target_if.slave  bus,
  input  logic [ADDR_BITS-1:0] host_addr,
  input  logic [31:0]          host_wdata,
  input  logic                 host_we,
  output logic [31:0]          host_rdata,
  output logic [2:0]           state,
  output logic                 xfer_done
);
  localparam int A = ADDR_BITS + 2;
  localparam bit Q = QUAD_MODE != 0;
  localparam logic [5:0] ALAST = Q ? 6'd5 : 6'd23;
  localparam logic [5:0] DLAST = Q ? 6'd7 : 6'd31;
  localparam logic [5:0] WLAST = 6'(WAIT_CLKS - 1);
  localparam logic [3:0] OE_RD = Q ? 4'hf : 4'h2;
  state_e state_q;
  logic [5:0] cnt_q, last_cnt;
  logic [7:0] cmd_q, cmd_nx;
  logic [A-1:0] addr_q, addr_nx;
  logic [31:0] sh_q, sh_nx, spi_rdata_q, host_rdata_q;
  logic [3:0] di_m_q, di_s_q, sio_do_q, sio_oe_q;
  logic xfer_done_q, ld_q, pend_q;
  logic ss_rise, ss_fall, sclk_rise, sclk_fall;
  logic last, cmd_ok, cmd_wr, rd_issue, spi_we;
  logic [31:0] mem [2**ADDR_BITS];
  qqspi_sync_edge #(.RST_VAL(1'b1)) u_ss (.clk(clk), .reset(reset), .d_i(bus.ss), .rise_o(ss_rise), .fall_o(ss_fall));
  qqspi_sync_edge #(.RST_VAL(1'b0)) u_sclk (.clk(clk), .reset(reset), .d_i(bus.sclk), .rise_o(sclk_rise), .fall_o(sclk_fall));
  // Keeping only A address bits makes higher bits alias modulo the RAM depth and drops addr[23].
  always_comb begin
    cmd_nx = {cmd_q[6:0], di_s_q[0]};
    addr_nx = Q ? {addr_q[A-5:0], di_s_q} : {addr_q[A-2:0], di_s_q[0]};
    sh_nx = Q ? {sh_q[27:0], di_s_q} : {sh_q[30:0], di_s_q[0]};
    last_cnt = state_q == S_CMD ? 6'd7 : state_q == S_ADDR ? ALAST : state_q == S_WAIT ? WLAST : DLAST;
    last = cnt_q == last_cnt;
    cmd_ok = Q ? (cmd_nx == CMD_WRITE_QUAD || cmd_nx == CMD_READ_QUAD) : (cmd_nx == CMD_WRITE_SPI || cmd_nx == CMD_READ_SPI);
    cmd_wr = cmd_q == (Q ? CMD_WRITE_QUAD : CMD_WRITE_SPI);
    rd_issue = !ss_rise && sclk_rise && last && state_q == S_ADDR && !cmd_wr;
    spi_we = !ss_rise && sclk_rise && last && state_q == S_WDATA;
  end
  // Port A (SPI) wins a same-word collision with port B (host).
  always_ff @(posedge clk) begin
    if (spi_we) mem[addr_q[A-1:2]] <= sh_nx;
    if (host_we && !(spi_we && addr_q[A-1:2] == host_addr)) mem[host_addr] <= host_wdata;
    if (rd_issue) spi_rdata_q <= mem[addr_nx[A-1:2]];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      host_rdata_q <= '0;
      di_m_q <= '0;
      di_s_q <= '0;
    end else begin
      host_rdata_q <= mem[host_addr];
      di_m_q <= bus.sio_di;
      di_s_q <= di_m_q;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      cmd_q <= '0;
      addr_q <= '0;
      sh_q <= '0;
      sio_do_q <= '0;
      sio_oe_q <= '0;
      xfer_done_q <= 1'b0;
      ld_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      xfer_done_q <= 1'b0;
      if (ss_rise) begin
        state_q <= S_IDLE;
        cnt_q <= '0;
        sio_do_q <= '0;
        sio_oe_q <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            sio_do_q <= '0;
            sio_oe_q <= '0;
            cnt_q <= '0;
            if (ss_fall) state_q <= S_CMD;
          end
          S_CMD: if (sclk_rise) begin
            cmd_q <= cmd_nx;
            cnt_q <= last ? 6'd0 : cnt_q + 6'd1;
            if (last) state_q <= cmd_ok ? S_ADDR : S_DROP;
          end
          S_ADDR: if (sclk_rise) begin
            addr_q <= addr_nx;
            cnt_q <= last ? 6'd0 : cnt_q + 6'd1;
            if (last) begin
              ld_q <= !cmd_wr;
              pend_q <= 1'b0;
              state_q <= cmd_wr ? S_WDATA : (cmd_q == CMD_READ_QUAD && WAIT_CLKS != 0) ? S_WAIT : S_RDATA;
            end
          end
          S_WAIT: if (sclk_rise) begin
            cnt_q <= last ? 6'd0 : cnt_q + 6'd1;
            if (last) state_q <= S_RDATA;
          end
          // The fall right after entry precedes the master's first sample, so a shift waits for a rise (pend_q).
          S_RDATA: if (ld_q) begin
            ld_q <= 1'b0;
            sio_oe_q <= OE_RD;
            sio_do_q <= out_unit(spi_rdata_q[31:28], Q);
            sh_q <= spi_rdata_q << (Q ? 4 : 1);
          end else if (sclk_rise) begin
            pend_q <= 1'b1;
            cnt_q <= last ? 6'd0 : cnt_q + 6'd1;
            if (last) begin
              sio_oe_q <= '0;
              sio_do_q <= '0;
              xfer_done_q <= 1'b1;
              state_q <= S_DROP;
            end
          end else if (sclk_fall && pend_q) begin
            pend_q <= 1'b0;
            sio_do_q <= out_unit(sh_q[31:28], Q);
            sh_q <= sh_q << (Q ? 4 : 1);
          end
          S_WDATA: if (sclk_rise) begin
            sh_q <= sh_nx;
            cnt_q <= last ? 6'd0 : cnt_q + 6'd1;
            if (last) begin
              xfer_done_q <= 1'b1;
              state_q <= S_DROP;
            end
          end
          S_DROP: begin
            sio_do_q <= '0;
            sio_oe_q <= '0;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end
  assign bus.sio_do = sio_do_q;
  assign bus.sio_oe = sio_oe_q;
  assign host_rdata = host_rdata_q;
  assign state = state_q;
  assign xfer_done = xfer_done_q;
endmodule

// File: tb/tb_qqspi_psram_target.sv
// tb_qqspi_psram_target: directed vectors plus corner sequences for quad and single-mode targets
module tb_qqspi_psram_target;
  localparam time HP = 80ns;
  localparam int OP_HW = 0, OP_HR = 1, OP_SW = 2, OP_SR = 3;
  typedef struct {
    int op;
    bit sel;
    logic [7:0] cmd;
    logic [23:0] addr;
    logic [31:0] data;
  } vec_t;
  logic clk = 1'b0, rst = 1'b0;
  logic sel, ss_v, sclk_v;
  logic [3:0] di_v, do_v, oe_v;
  logic [9:0] q_ha, s_ha;
  logic [31:0] q_hwd, s_hwd, q_hrd, s_hrd;
  logic q_hwe, s_hwe, q_done, s_done;
  logic [2:0] q_st, s_st;
  int n_vec = 0, n_bad = 0, q_dn = 0, s_dn = 0, oe_hits = 0;
  bit mon_oe = 1'b0;
  vec_t v[14];
  always #5ns clk = ~clk;
  qqspi_psram_target_if qb();
  qqspi_psram_target_if sb();
  assign qb.ss = sel ? 1'b1 : ss_v;
  assign qb.sclk = sel ? 1'b0 : sclk_v;
  assign qb.sio_di = sel ? 4'h0 : di_v;
  assign sb.ss = sel ? ss_v : 1'b1;
  assign sb.sclk = sel ? sclk_v : 1'b0;
  assign sb.sio_di = sel ? di_v : 4'h0;
  assign do_v = sel ? sb.sio_do : qb.sio_do;
  assign oe_v = sel ? sb.sio_oe : qb.sio_oe;
  qqspi_psram_target #(.QUAD_MODE(1)) dq (
    .clk(clk), .reset(rst), .bus(qb), .host_addr(q_ha), .host_wdata(q_hwd), .host_we(q_hwe),
    .host_rdata(q_hrd), .state(q_st), .xfer_done(q_done));
  qqspi_psram_target #(.QUAD_MODE(0)) ds (
    .clk(clk), .reset(rst), .bus(sb), .host_addr(s_ha), .host_wdata(s_hwd), .host_we(s_hwe),
    .host_rdata(s_hrd), .state(s_st), .xfer_done(s_done));
  always @(posedge clk) begin
    if (q_done) q_dn++;
    if (s_done) s_dn++;
    if (mon_oe && qb.sio_oe != 4'h0) oe_hits++;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask
  function automatic int dn(input bit s);
    return s ? s_dn : q_dn;
  endfunction
  function automatic logic [2:0] st(input bit s);
    return s ? s_st : q_st;
  endfunction
  task automatic host_write(input bit s, input logic [9:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    if (s) begin s_ha = a; s_hwd = d; s_hwe = 1'b1; end
    else begin q_ha = a; q_hwd = d; q_hwe = 1'b1; end
    @(posedge clk); #1;
    s_hwe = 1'b0;
    q_hwe = 1'b0;
  endtask
  task automatic host_read(input bit s, input logic [9:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    if (s) s_ha = a; else q_ha = a;
    @(posedge clk); #1;
    d = s ? s_hrd : q_hrd;
  endtask
  task automatic clk_unit(input logic [3:0] d);
    di_v = d;
    #HP sclk_v = 1'b1;
    #HP sclk_v = 1'b0;
  endtask
  task automatic send(input logic [31:0] w, input int n, input bit q);
    for (int i = 0; i < n; i++) clk_unit(q ? w[31-4*i -: 4] : {3'b000, w[31-i]});
  endtask
  task automatic start(input logic [7:0] cmd, input logic [23:0] a, input bit q);
    ss_v = 1'b0;
    #HP;
    send({cmd, 24'h0}, 8, 1'b0);
    send({a, 8'h0}, q ? 6 : 24, q);
  endtask
  task automatic stop();
    #HP ss_v = 1'b1;
    #(4*HP);
  endtask
  task automatic spi_write(input logic [7:0] cmd, input logic [23:0] a, input logic [31:0] d, input bit q);
    start(cmd, a, q);
    send(d, q ? 8 : 32, q);
    stop();
  endtask
  task automatic spi_read(input logic [7:0] cmd, input logic [23:0] a, input bit q, input int waits,
                          output logic [31:0] d, output bit oe_ok);
    start(cmd, a, q);
    repeat (waits) clk_unit(4'h0);
    d = '0;
    oe_ok = 1'b1;
    for (int i = 0; i < (q ? 8 : 32); i++) begin
      di_v = 4'h0;
      #HP;
      d = q ? {d[27:0], do_v} : {d[30:0], do_v[1]};
      if (oe_v !== (q ? 4'hf : 4'h2)) oe_ok = 1'b0;
      sclk_v = 1'b1;
      #HP sclk_v = 1'b0;
    end
    stop();
  endtask
  initial begin
    logic [31:0] d;
    bit ok, seen;
    int n0;
    sel = 1'b0; ss_v = 1'b1; sclk_v = 1'b0; di_v = 4'h0;
    q_ha = '0; s_ha = '0; q_hwd = '0; s_hwd = '0; q_hwe = 1'b0; s_hwe = 1'b0;
    #3 rst = 1'b1;
    #30;
    chk("reset q sio_oe", qb.sio_oe, 0);
    chk("reset q sio_do", qb.sio_do, 0);
    chk("reset q state", q_st, 0);
    chk("reset q xfer_done", q_done, 0);
    chk("reset q host_rdata", q_hrd, 0);
    chk("reset s sio_oe", sb.sio_oe, 0);
    chk("reset s state", s_st, 0);
    chk("reset s host_rdata", s_hrd, 0);
    @(negedge clk) rst = 1'b0;
    v[0] = '{OP_HW, 1'b0, 8'h00, 24'd5, 32'hdeadbeef};
    v[1] = '{OP_SR, 1'b0, 8'heb, 24'h000014, 32'hdeadbeef};
    v[2] = '{OP_SW, 1'b0, 8'h38, 24'h000020, 32'h12345678};
    v[3] = '{OP_HR, 1'b0, 8'h00, 24'd8, 32'h12345678};
    v[4] = '{OP_SW, 1'b0, 8'h38, 24'h800030, 32'h0badf00d};
    v[5] = '{OP_HR, 1'b0, 8'h00, 24'd12, 32'h0badf00d};
    v[6] = '{OP_SW, 1'b0, 8'h38, 24'h001034, 32'h600dcafe};
    v[7] = '{OP_HR, 1'b0, 8'h00, 24'd13, 32'h600dcafe};
    v[8] = '{OP_SR, 1'b0, 8'heb, 24'h000022, 32'h12345678};
    v[9] = '{OP_SW, 1'b1, 8'h02, 24'h000004, 32'hcafef00d};
    v[10] = '{OP_SR, 1'b1, 8'h03, 24'h000004, 32'hcafef00d};
    v[11] = '{OP_HR, 1'b1, 8'h00, 24'd1, 32'hcafef00d};
    v[12] = '{OP_HW, 1'b1, 8'h00, 24'd7, 32'h13579bdf};
    v[13] = '{OP_SR, 1'b1, 8'h03, 24'h00001c, 32'h13579bdf};
    for (int i = 0; i < 14; i++) begin
      sel = v[i].sel;
      n0 = dn(v[i].sel);
      case (v[i].op)
        OP_HW: host_write(v[i].sel, v[i].addr[9:0], v[i].data);
        OP_HR: begin
          host_read(v[i].sel, v[i].addr[9:0], d);
          chk($sformatf("v%0d host word", i), d, v[i].data);
        end
        OP_SW: begin
          spi_write(v[i].cmd, v[i].addr, v[i].data, !v[i].sel);
          chk($sformatf("v%0d write done count", i), dn(v[i].sel) - n0, 1);
          chk($sformatf("v%0d state after write", i), st(v[i].sel), 0);
        end
        default: begin
          spi_read(v[i].cmd, v[i].addr, !v[i].sel, v[i].cmd == 8'heb ? 6 : 0, d, ok);
          chk($sformatf("v%0d read data", i), d, v[i].data);
          chk($sformatf("v%0d read oe", i), 32'(ok), 1);
          chk($sformatf("v%0d oe after read", i), oe_v, 0);
          chk($sformatf("v%0d read done count", i), dn(v[i].sel) - n0, 1);
        end
      endcase
    end
    sel = 1'b0;
    host_write(1'b0, 10'd3, 32'h33333333);
    n0 = q_dn;
    start(8'h38, 24'h00000c, 1'b1);
    send(32'ha5a5a5a5, 4, 1'b1);
    stop();
    host_read(1'b0, 10'd3, d);
    chk("partial write word3", d, 32'h33333333);
    chk("partial write done count", q_dn - n0, 0);
    chk("partial write state", q_st, 0);
    n0 = oe_hits;
    mon_oe = 1'b1;
    ss_v = 1'b0;
    #HP;
    send({8'h9f, 24'h0}, 8, 1'b0);
    chk("bad cmd state", q_st, 6);
    send(32'hffffffff, 8, 1'b1);
    stop();
    mon_oe = 1'b0;
    chk("bad cmd oe hits", oe_hits - n0, 0);
    chk("bad cmd state after ss", q_st, 0);
    spi_read(8'heb, 24'h000014, 1'b1, 6, d, ok);
    chk("read after bad cmd", d, 32'hdeadbeef);
    q_ha = 10'd2;
    q_hwd = 32'h11111111;
    q_hwe = 1'b1;
    seen = 1'b0;
    fork
      spi_write(8'h38, 24'h000008, 32'h22222222, 1'b1);
      begin
        for (int i = 0; i < 20000 && !seen; i++) begin
          @(posedge clk); #1;
          if (q_done) seen = 1'b1;
        end
        q_hwe = 1'b0;
        @(posedge clk); #1;
        chk("collision host_rdata next clk", q_hrd, 32'h22222222);
      end
    join
    chk("collision commit seen", 32'(seen), 1);
    host_read(1'b0, 10'd2, d);
    chk("collision word2", d, 32'h22222222);
    start(8'heb, 24'h000014, 1'b1);
    repeat (6) clk_unit(4'h0);
    repeat (2) clk_unit(4'h0);
    #(HP/2);
    chk("oe before reset", qb.sio_oe, 32'hf);
    rst = 1'b1;
    #1;
    chk("reset mid read oe", qb.sio_oe, 0);
    chk("reset mid read do", qb.sio_do, 0);
    chk("reset mid read state", q_st, 0);
    chk("reset mid read host_rdata", q_hrd, 0);
    ss_v = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    host_read(1'b0, 10'd5, d);
    chk("ram kept through reset", d, 32'hdeadbeef);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
